// File: rtl/timing_sequencer_team1_if.sv
// Bus bundle for timing_sequencer_team1: instruction decode and flag inputs, timing and status outputs.
// The master modport drives the decode inputs; the sequencer attaches through the slave modport.
interface timing_sequencer_team1_if #(
    parameter int SC_W = 4
);
    logic                 START;
    logic                 HLT;
    logic [7:0]           D;
    logic                 r;
    logic [11:0]          B;
    logic                 IEN;
    logic                 FGI;
    logic                 FGO;
    logic [SC_W-1:0]      SC;
    logic [2**SC_W-1:0]   T;
    logic                 R;
    logic                 INST_DONE;
    logic [1:0]           STATE;
    logic                 WDT_ERR;

    modport master (
        output START, HLT, D, r, B, IEN, FGI, FGO,
        input  SC, T, R, INST_DONE, STATE, WDT_ERR
    );

    modport slave (
        input  START, HLT, D, r, B, IEN, FGI, FGO,
        output SC, T, R, INST_DONE, STATE, WDT_ERR
    );
endinterface

// File: rtl/timing_sequencer_team1.sv
// Instruction timing sequencer: steps SC through T0..Tn, runs the interrupt cycle and honours halt.
// Optional stuck-sequence watchdog is built when SEQ_WATCHDOG_EN is defined.
module timing_sequencer_team1 #(
    parameter int SC_W = 4
) (
    input  logic                    clk,
    input  logic                    CLR_GLOBAL_N,
    timing_sequencer_team1_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic               r_q, r_d;
    logic [2**SC_W-1:0] t_dec;
    logic               end_cond;
    logic               halt_instr;
    logic               run_en;
    logic               unused_b;

    assign unused_b = ^bus.B[11:1];

    always_comb begin
        t_dec = '0;
        if (state_q == RUN) t_dec[sc_q] = 1'b1;
    end

    // t_dec is zero outside RUN, so the end terms only fire while sequencing.
    always_comb begin
        end_cond = (r_q & t_dec[2])
                 | (~r_q & (bus.D[0] | bus.D[1] | bus.D[2] | bus.D[5]) & t_dec[5])
                 | (~r_q & (bus.D[3] | bus.D[4] | bus.D[7]) & t_dec[4])
                 | (~r_q & bus.D[6] & t_dec[6])
                 | (~r_q & bus.r & t_dec[4]);
        halt_instr = ~r_q & bus.r & bus.B[0] & t_dec[4];
        run_en     = (state_q == RUN) & ~bus.HLT;
    end

`ifdef SEQ_WATCHDOG_EN
    logic wdt_q, wdt_d;
`endif

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        r_d     = r_q;
`ifdef SEQ_WATCHDOG_EN
        wdt_d   = wdt_q;
`endif
        unique case (state_q)
            IDLE, HALT: begin
                sc_d = '0;
                if (bus.START) state_d = RUN;
            end
            RUN: begin
                if (!bus.HLT) begin
                    if (end_cond) begin
                        sc_d = '0;
                        r_d  = r_q ? 1'b0 : (bus.IEN & (bus.FGI | bus.FGO));
                        if (halt_instr) state_d = HALT;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (&sc_q) begin
                        sc_d    = '0;
                        state_d = HALT;
                        wdt_d   = 1'b1;
                    end
`endif
                    else begin
                        sc_d = sc_q + SC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge CLR_GLOBAL_N) begin
        if (!CLR_GLOBAL_N) begin
            state_q <= IDLE;
            sc_q    <= '0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            r_q     <= r_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk or negedge CLR_GLOBAL_N) begin
        if (!CLR_GLOBAL_N) wdt_q <= 1'b0;
        else               wdt_q <= wdt_d;
    end
    assign bus.WDT_ERR = wdt_q;
`else
    assign bus.WDT_ERR = 1'b0;
`endif

    assign bus.SC        = sc_q;
    assign bus.T         = t_dec;
    assign bus.R         = r_q;
    assign bus.INST_DONE = run_en & end_cond;
    assign bus.STATE     = state_q;
endmodule

// File: tb/tb_timing_sequencer_team1.sv
// Self-checking bench for timing_sequencer_team1: directed vector table, async reset and watchdog
// sequences, then randomized stimulus against an instruction-length reference model.
module tb_timing_sequencer_team1;
    localparam int SC_W = 4;
`ifdef SEQ_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    timing_sequencer_team1_if #(.SC_W(SC_W)) bus ();

    timing_sequencer_team1 #(.SC_W(SC_W)) dut (
        .clk          (clk),
        .CLR_GLOBAL_N (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        hlt;
        logic [7:0]  d;
        logic        rr;
        logic [11:0] b;
        logic        ien;
        logic        fgi;
        logic        fgo;
        int          exp_sc;
        int          exp_state;
        int          exp_done;
        int          exp_r;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  cur_d;
    logic        cur_rr;
    logic [11:0] cur_b;
    logic        cur_ien, cur_fgi, cur_fgo;

    // Reference model: instruction length by opcode, interrupt cycle is three steps.
    int m_state, m_sc, m_r, m_wdt;
    int op_len [8] = '{5, 5, 5, 4, 4, 5, 6, 4};

    function automatic int m_finishing();
        if (m_state != 1) return 0;
        if (m_r != 0) return (m_sc == 2) ? 1 : 0;
        if (bus.r && m_sc == 4) return 1;
        for (int i = 0; i < 8; i++)
            if (bus.D[i] && m_sc == op_len[i]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_sc    = 0;
        m_r     = 0;
        m_wdt   = 0;
    endtask

    task automatic model_step();
        int fin, is_halt;
        if (m_state != 1) begin
            m_sc = 0;
            if (bus.START) m_state = 1;
        end else if (!bus.HLT) begin
            fin     = m_finishing();
            is_halt = (m_r == 0 && bus.r && bus.B[0] && m_sc == 4) ? 1 : 0;
            if (fin != 0) begin
                m_r  = (m_r != 0) ? 0 : ((bus.IEN && (bus.FGI || bus.FGO)) ? 1 : 0);
                m_sc = 0;
                if (is_halt != 0) m_state = 2;
            end else if (WD_ON && m_sc == 15) begin
                m_sc    = 0;
                m_state = 2;
                m_wdt   = 1;
            end else begin
                m_sc = (m_sc + 1) % 16;
            end
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_output(input int exp_sc, input int exp_state, input int exp_done,
                                input int exp_r, input int exp_wdt, input string tag);
        int exp_t;
        exp_t = (exp_state == 1) ? (1 << exp_sc) : 0;
        check_val({tag, ".SC"},        int'(bus.SC),        exp_sc);
        check_val({tag, ".STATE"},     int'(bus.STATE),     exp_state);
        check_val({tag, ".T"},         int'(bus.T),         exp_t);
        check_val({tag, ".INST_DONE"}, int'(bus.INST_DONE), exp_done);
        check_val({tag, ".R"},         int'(bus.R),         exp_r);
        check_val({tag, ".WDT_ERR"},   int'(bus.WDT_ERR),   exp_wdt);
    endtask

    task automatic check_model(input string tag);
        int exp_done;
        exp_done = (m_state == 1 && !bus.HLT) ? m_finishing() : 0;
        check_output(m_sc, m_state, exp_done, m_r, m_wdt, tag);
    endtask

    task automatic apply_stimulus(input logic start, input logic hlt, input logic [7:0] d,
                                  input logic rr, input logic [11:0] b,
                                  input logic ien, input logic fgi, input logic fgo);
        bus.START = start;
        bus.HLT   = hlt;
        bus.D     = d;
        bus.r     = rr;
        bus.B     = b;
        bus.IEN   = ien;
        bus.FGI   = fgi;
        bus.FGO   = fgo;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic add(input logic start, input logic hlt, input int sc, input int st,
                       input int done, input int rf);
        vec_t v;
        v.start = start;  v.hlt = hlt;  v.d = cur_d;  v.rr = cur_rr;  v.b = cur_b;
        v.ien = cur_ien;  v.fgi = cur_fgi;  v.fgo = cur_fgo;
        v.exp_sc = sc;  v.exp_state = st;  v.exp_done = done;  v.exp_r = rf;
        vecs.push_back(v);
    endtask

    task automatic set_ops(input logic [7:0] d, input logic rr, input logic [11:0] b,
                           input logic ien, input logic fgi, input logic fgo);
        cur_d = d;  cur_rr = rr;  cur_b = b;  cur_ien = ien;  cur_fgi = fgi;  cur_fgo = fgo;
    endtask

    initial begin
        // Memory-reference D0 instruction: T0..T5 then back to T0.
        set_ops(8'h01, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        add(1, 0, 0, 0, 0, 0);
        for (int s = 0; s < 5; s++) add(0, 0, s, 1, 0, 0);
        add(0, 0, 5, 1, 1, 0);
        // D6 with a pending input flag: ends at T6, then a three-step interrupt cycle.
        set_ops(8'h40, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 6; s++) add(0, 0, s, 1, 0, 0);
        add(0, 0, 6, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 1);
        add(0, 0, 2, 1, 1, 1);
        // Register-reference halt, then restart from HALT.
        set_ops(8'h00, 1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) add(0, 0, s, 1, 0, 0);
        add(0, 0, 4, 1, 1, 0);
        add(1, 0, 0, 2, 0, 0);
        // D3 with a three-cycle stall at T3 and a stall on the ending T4.
        set_ops(8'h08, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) add(0, 0, s, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 3, 1, 0, 0);
        add(0, 0, 3, 1, 0, 0);
        add(0, 1, 4, 1, 0, 0);
        add(0, 0, 4, 1, 1, 0);
        // Halt again, then START together with HLT.
        set_ops(8'h00, 1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) add(0, 0, s, 1, 0, 0);
        add(0, 0, 4, 1, 1, 0);
        add(1, 1, 0, 2, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0);

        rst_n = 1'b0;
        apply_stimulus(0, 0, 8'h00, 0, 12'h000, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_output(0, 0, 0, 0, 0, "reset");
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].start, vecs[i].hlt, vecs[i].d, vecs[i].rr, vecs[i].b,
                           vecs[i].ien, vecs[i].fgi, vecs[i].fgo);
            #1;
            check_output(vecs[i].exp_sc, vecs[i].exp_state, vecs[i].exp_done,
                         vecs[i].exp_r, 0, $sformatf("vec%0d", i));
            tick();
        end

        // Asynchronous reset between edges while at T2.
        #1;
        check_output(2, 1, 0, 0, 0, "pre_reset");
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_output(0, 0, 0, 0, 0, "async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // No end condition: watchdog trips at T15, otherwise SC wraps to 0.
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(i == 0, 0, 8'h00, 0, 12'h000, 0, 0, 0);
            #1;
            check_model($sformatf("wdt%0d", i));
            if (i == 16) check_val("wdt_sc15", int'(bus.SC), 15);
            if (i == 17) begin
                check_val("wdt_err",   int'(bus.WDT_ERR), WD_ON ? 1 : 0);
                check_val("wdt_state", int'(bus.STATE),   WD_ON ? 2 : 1);
                check_val("wdt_sc",    int'(bus.SC),      0);
            end
            tick();
        end

        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
            apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, d,
                           $urandom_range(0, 5) == 0, 12'($urandom()),
                           1'($urandom()), 1'($urandom()), 1'($urandom()));
            #1;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
